// File: rtl/pe_drain_8.sv
// Drain stage for one systolic column: skewed capture, saturate/requantise, show-ahead FIFO out.
// Define PE_DRAIN_ROUND_EN for round-half-up requantisation; the default build truncates (floor).
module pe_drain_8 #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 3,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [7:0]               lat_i,
  input  logic [7:0]               cnt_i,
  input  logic signed [ACC_BW-1:0] acc_i,
  output logic signed [MUL_BW-1:0] res_o,
  output logic                     res_vld_o,
  input  logic                     res_rdy_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ovf_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SAT_W = INT_BW + 2 * FRA_BW;
  localparam int Q_W   = INT_BW + FRA_BW;
  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << SAT_W) - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MIN = -(ACC_BW'(1 << SAT_W));
  localparam logic signed [ACC_BW-1:0] Q_MAX   = ACC_BW'((1 << Q_W) - 1);
  localparam logic signed [ACC_BW-1:0] Q_MIN   = -(ACC_BW'(1 << Q_W));
`ifdef PE_DRAIN_ROUND_EN
  localparam logic signed [ACC_BW-1:0] RND     = ACC_BW'(1 << (FRA_BW - 1));
`endif

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, FLUSH} state_t;

  state_t                   state;
  logic [7:0]               wcnt, ccnt;
  logic                     done, ovf;
  logic [AW:0]              wr_ptr, rd_ptr, level;
  logic [MUL_BW-1:0]        mem [DEPTH];
  logic [MUL_BW-1:0]        last;
  logic                     empty, full, pop, capt, push, drop, next_empty;
  logic signed [ACC_BW-1:0] sat, rnd, shf;
  logic [MUL_BW-1:0]        conv;

  // Sign-extension to MUL_BW falls out of slicing the full-width signed clamp result.
  always_comb begin
    sat = acc_i;
    if (acc_i > SAT_MAX)      sat = SAT_MAX;
    else if (acc_i < SAT_MIN) sat = SAT_MIN;
`ifdef PE_DRAIN_ROUND_EN
    rnd = sat + RND;
`else
    rnd = sat;
`endif
    shf = rnd >>> FRA_BW;
    if (shf > Q_MAX)      conv = Q_MAX[MUL_BW-1:0];
    else if (shf < Q_MIN) conv = Q_MIN[MUL_BW-1:0];
    else                  conv = shf[MUL_BW-1:0];
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign pop   = !empty && res_rdy_i;
  assign capt  = (state == CAPT);
  // A same-cycle pop frees a slot, so a full FIFO only drops when nothing leaves.
  assign push  = capt && (!full || pop);
  assign drop  = capt && full && !pop;
  assign next_empty = !push && (empty || (level == (AW+1)'(1) && pop));

  // done is raised one cycle ahead of the empty FIFO so it lands while still in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      ccnt  <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (drop) ovf <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          wcnt <= lat_i;
          ccnt <= cnt_i;
          ovf  <= 1'b0;
          if (cnt_i == 8'd0)      state <= FLUSH;
          else if (lat_i != 8'd0) state <= WAIT;
          else                    state <= CAPT;
        end
        WAIT: begin
          wcnt <= wcnt - 8'd1;
          if (wcnt == 8'd1) state <= CAPT;
        end
        CAPT: begin
          ccnt <= ccnt - 8'd1;
          if (ccnt == 8'd1) state <= FLUSH;
        end
        FLUSH: begin
          if (done)            state <= IDLE;
          else if (next_empty) done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        last   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= conv;
  end

  assign res_o     = empty ? last : mem[rd_ptr[AW-1:0]];
  assign res_vld_o = !empty;
  assign busy_o    = (state != IDLE);
  assign done_o    = done;
  assign ovf_o     = ovf;

endmodule

// File: tb/tb_pe_drain_8.sv
// Bench for pe_drain_8: directed and random drain jobs checked against a queue-based job model.
// Build with PE_DRAIN_ROUND_EN defined to match a rounding DUT.
module tb_pe_drain_8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic [7:0]         lat_i, cnt_i;
  logic signed [31:0] acc_i;
  logic [15:0]        res_o;
  logic               res_vld_o, res_rdy_i, busy_o, done_o, ovf_o;

  int tests = 0;
  int fails = 0;

  // Job model: expected results live in a queue, timing comes from start cycle, latency and count.
  int q[$];
  int last_m;
  bit in_job;
  bit ovf_m;
  int t_s, jlat, jcnt;
  int cyc;
  int done_cyc;

  pe_drain_8 dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .lat_i(lat_i), .cnt_i(cnt_i),
    .acc_i(acc_i), .res_o(res_o), .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  function automatic int conv_model(input int a);
    int s, num, r;
    s = (a > 2047) ? 2047 : ((a < -2048) ? -2048 : a);
`ifdef PE_DRAIN_ROUND_EN
    num = s + 4;
`else
    num = s;
`endif
    r = (num - (((num % 8) + 8) % 8)) / 8;
    if (r > 255)  r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  function automatic int flush_at();
    return (jcnt == 0) ? t_s + 1 : t_s + jlat + jcnt + 1;
  endfunction

  function automatic logic signed [31:0] pick_acc(input int mode, input int k, input int lat);
    int sp[6] = '{100, -100, 5000, -5000, 2047, -2048};
    int r;
    if (mode == 1) return 32'(8 * (k - lat));
    if (mode == 2) return 32'(sp[(k > lat) ? (k - lat - 1) % 6 : 0]);
    r = int'($urandom_range(3));
    if (r == 0) return $urandom;
    return 32'(int'($urandom_range(12000)) - 6000);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_m = 0;
    in_job = 0;
    ovf_m  = 0;
  endtask

  task automatic apply_stimulus(input logic st, input logic [7:0] lat, input logic [7:0] cnt,
                                input logic signed [31:0] acc, input logic rdy);
    bit exp_done, was_job;
    logic [15:0] exp_res;
    start_i = st; lat_i = lat; cnt_i = cnt; acc_i = acc; res_rdy_i = rdy;
    @(negedge clk);
    exp_done = in_job && (cyc > flush_at()) && (q.size() == 0);
    exp_res  = (q.size() != 0) ? 16'(q[0]) : 16'(last_m);
    check_output("res_vld", 32'(res_vld_o), 32'(q.size() != 0));
    check_output("res", 32'(res_o), 32'(exp_res));
    check_output("busy", 32'(busy_o), 32'(in_job));
    check_output("done", 32'(done_o), 32'(exp_done));
    check_output("ovf", 32'(ovf_o), 32'(ovf_m));
    if (done_o === 1'b1) done_cyc = cyc;
    @(posedge clk);
    was_job = in_job;
    if (q.size() != 0 && rdy) last_m = q.pop_front();
    if (in_job && cyc >= t_s + 1 + jlat && cyc <= t_s + jlat + jcnt) begin
      if (q.size() < 4) q.push_back(conv_model(int'(acc)));
      else ovf_m = 1;
    end
    if (exp_done) in_job = 0;
    if (!was_job && st) begin
      in_job = 1; t_s = cyc; jlat = int'(lat); jcnt = int'(cnt); ovf_m = 0;
    end
    #1;
    cyc++;
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stalled until capture is over
  task automatic run_job(input int lat, input int cnt, input int acc_mode, input int rdy_mode,
                         input bit again, output int t0);
    int k, n;
    logic rdy, st;
    t0 = cyc;
    apply_stimulus(1'b1, 8'(lat), 8'(cnt), pick_acc(acc_mode, 0, lat), (rdy_mode != 2));
    n = 0;
    while (in_job && n < 2000) begin
      k = cyc - t0;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(1) == 1);
        default: rdy = (k > lat + cnt + 2);
      endcase
      st = again && cnt >= 3 && k == lat + 2;
      apply_stimulus(st, 8'd1, 8'd1, pick_acc(acc_mode, k, lat), rdy);
      n++;
    end
    check_output("job_timeout", 32'(in_job), 32'd0);
    apply_stimulus(1'b0, 8'd0, 8'd0, pick_acc(0, 0, 0), 1'b1);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; start_i = 1'b0; lat_i = '0; cnt_i = '0; acc_i = '0; res_rdy_i = 1'b0;
    model_reset();
    cyc = 0;
    done_cyc = -1;
    #12;
    check_output("rst_vld", 32'(res_vld_o), 32'd0);
    check_output("rst_res", 32'(res_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(3, 4, 1, 0, 1'b0, t0);
    check_output("basic_done_cycle", 32'(done_cyc - t0), 32'd9);

    run_job(0, 6, 2, 0, 1'b0, t0);
    run_job(2, 6, 0, 2, 1'b0, t0);
    run_job(5, 0, 0, 0, 1'b0, t0);
    check_output("cnt0_done_cycle", 32'(done_cyc - t0), 32'd2);
    run_job(0, 3, 0, 0, 1'b0, t0);
    run_job(1, 5, 0, 1, 1'b1, t0);

    for (int j = 0; j < 10; j++)
      run_job(int'($urandom_range(6)), int'($urandom_range(9)), int'($urandom_range(2)),
              int'($urandom_range(1)), ($urandom_range(1) == 1), t0);

    // Abort a job in CAPT with two results queued.
    apply_stimulus(1'b1, 8'd0, 8'd8, pick_acc(0, 0, 0), 1'b0);
    apply_stimulus(1'b0, 8'd0, 8'd0, pick_acc(0, 0, 0), 1'b0);
    apply_stimulus(1'b0, 8'd0, 8'd0, pick_acc(0, 0, 0), 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("abort_vld", 32'(res_vld_o), 32'd0);
    check_output("abort_busy", 32'(busy_o), 32'd0);
    check_output("abort_ovf", 32'(ovf_o), 32'd0);
    check_output("abort_res", 32'(res_o), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    run_job(1, 4, 0, 1, 1'b0, t0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
